bounce_counter_multimode: RTL and testbench
===========================================

# bounce_counter_multimode

Parametrised successor to the team's fixed 16-bit up/down bounce counter. Counts between programmable lower and upper limits with a programmable step. Selectable modes: bounce (ping-pong), wrap-up, wrap-down and one-shot. Used as a sweep/scan address generator and PWM-style ramp source in the datapath, driven from a single clock domain.

## Interface
- WIDTH, 16, count/data/limit width
- STEP_W, 4, step width; step is unsigned, 0 legal (count holds)
- RST_VAL, 0, count value after reset
- TC_W, 8, turn-counter width (only with UDC_TURN_CNT_EN)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- en  in  1  advance count this cycle
- load  in  1  load data into count
- data  in  WIDTH  load value
- upper_lim  in  WIDTH  upper bound, inclusive
- down_lim  in  WIDTH  lower bound, inclusive
- step  in  STEP_W  increment/decrement magnitude
- mode  in  2  0 bounce, 1 wrap-up, 2 wrap-down, 3 one-shot
- count  out  WIDTH  current value
- dir  out  1  0 = counting up, 1 = counting down
- turn  out  1  one-cycle flag: count just reversed or wrapped
- done  out  1  one-shot reached upper_lim, sticky
- cfg_err  out  1  down_lim > upper_lim this cycle (combinational)
- turn_cnt  out  TC_W  turns since reset/load (only with UDC_TURN_CNT_EN)

## Operation
- Priority: rst > load > en. No en, no load: all registers hold; turn <= 0.
- rst: count <= RST_VAL, dir <= 0, turn <= 0, done <= 0, turn_cnt <= 0.
- load: count <= data; turn <= 0; done <= 0; turn_cnt <= 0. dir <= 1 if mode is wrap-down, or if mode is bounce and data >= upper_lim; otherwise dir <= 0.
- cfg_err high: en is ignored, count holds, turn <= 0. load is still honoured.
- Arithmetic runs in WIDTH+1 bits. up(x) = min(x+step, upper_lim). dn(x) = max(x-step, down_lim), with underflow treated as below down_lim.
- Bounce, dir=0:
  - count >= upper_lim: count <= dn(count), dir <= 1, turn <= 1.
  - else: count <= up(count).
- Bounce, dir=1: mirror image. count <= down_lim triggers count <= up(count), dir <= 0, turn <= 1.
- Wrap-up: count >= upper_lim gives count <= down_lim, turn <= 1. Else count <= up(count). dir <= 0.
- Wrap-down: count <= down_lim gives count <= upper_lim, turn <= 1. Else count <= dn(count). dir <= 1.
- One-shot: count >= upper_lim gives hold and done <= 1; turn stays 0. Else count <= up(count). dir <= 0.
- Count outside the limits (after load, or after a limit change): treated by the same compares. Above upper while going up counts as a boundary hit, so the counter re-enters the range within one turn.
- Mode change mid-run: applies on the next enabled cycle. Entering bounce keeps the current dir. Entering a wrap mode forces dir as listed above.
- down_lim == upper_lim: bounce and wrap hold count at the limit, with turn high every enabled cycle.

## Timing
- All outputs are registered except cfg_err.
- Latency: one cycle from en/load to the new count.
- turn is high exactly in the cycle after the turning edge, coincident with the post-turn count.
- A limit or step change takes effect on the first enabled edge after it is presented. No internal pipelining.

## Configuration
- UDC_TURN_CNT_EN defined:
  - turn_cnt port and register exist.
  - turn_cnt increments on each turn and saturates at all-ones.
  - Cleared by rst or load.
- Undefined: the port is absent and no counter logic is built.
- All other behaviour is identical in both builds.

## Structure
- Package udc_pkg holds:
  - mode constants MODE_BOUNCE, MODE_WRAP_UP, MODE_WRAP_DN, MODE_ONESHOT
  - the 2-bit mode typedef
- One sub-module, udc_step_sat: combinational WIDTH-generic saturating add/sub clamped to a bound. Instantiated twice, for up() and dn().

## Test plan
- Bounce, lim 2..5, step 1, load 2: count 2,3,4,5,4,3,2,3. turn high with the first 4 and with the 3 after 2; dir toggles at those points.
- Bounce, lim 0..10, step 4, load 0: count 0,4,8,10,6,2,0,4 (clamped at bounds).
- Wrap-down, lim 3..6, step 2, load 6: count 6,4,3,6,4. turn high with each 6 after 3.
- One-shot, lim 0..3, step 1, load 0: count 0,1,2,3,3. done rises with the first 3 and stays high until load.
- Simultaneous rst+load+en: count = RST_VAL. load+en: count = data.
- down_lim=8, upper_lim=4: cfg_err=1 and count holds under en. With UDC_TURN_CNT_EN and TC_W=2, six bounce turns give turn_cnt saturating at 3.

Source files
------------

// File: rtl/udc_pkg.sv
// Shared definitions for the multimode bounce counter: mode encoding and its type.
package udc_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BOUNCE  = 2'd0;
    localparam mode_t MODE_WRAP_UP = 2'd1;
    localparam mode_t MODE_WRAP_DN = 2'd2;
    localparam mode_t MODE_ONESHOT = 2'd3;

endpackage

// File: rtl/udc_step_sat.sv
// Combinational step-and-clamp: value +/- step, evaluated in WIDTH+1 bits and clamped to bound.
// The add form clamps from above (min), the subtract form clamps from below (max).
module udc_step_sat #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned STEP_W   = 4,
    parameter bit          SUBTRACT = 1'b0
) (
    input  logic [WIDTH-1:0]  value,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  bound,
    output logic [WIDTH-1:0]  result
);

    logic [WIDTH:0] ext_val;
    logic [WIDTH:0] ext_step;
    logic [WIDTH:0] ext_bound;
    logic [WIDTH:0] raw;
    logic           clamp;

    assign ext_val   = {1'b0, value};
    assign ext_step  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign ext_bound = {1'b0, bound};

    // Raw step result and whether it crosses the bound
    always_comb begin
        if (SUBTRACT) begin
            raw   = ext_val - ext_step;
            // A borrow sets the extra MSB, which counts as below any bound
            clamp = raw[WIDTH] || (raw < ext_bound);
        end else begin
            raw   = ext_val + ext_step;
            clamp = raw > ext_bound;
        end
        result = clamp ? bound : raw[WIDTH-1:0];
    end

endmodule

// File: rtl/bounce_counter_multimode.sv
// Programmable-limit up/down counter with bounce, wrap-up, wrap-down and one-shot modes.
// Define UDC_TURN_CNT_EN to build the saturating turn counter and its turn_cnt port.
module bounce_counter_multimode
    import udc_pkg::*;
#(
    parameter int unsigned     WIDTH   = 16,
    parameter int unsigned     STEP_W  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int unsigned     TC_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  data,
    input  logic [WIDTH-1:0]  upper_lim,
    input  logic [WIDTH-1:0]  down_lim,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              turn,
    output logic              done,
    output logic              cfg_err
`ifdef UDC_TURN_CNT_EN
    ,
    output logic [TC_W-1:0]   turn_cnt
`endif
);

    mode_t            mode_sel;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] up_val, dn_val;
    logic             dir_q, dir_d;
    logic             turn_q, turn_d;
    logic             done_q, done_d;

    assign mode_sel = mode;
    assign cfg_err  = down_lim > upper_lim;

    udc_step_sat #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .SUBTRACT (1'b0)
    ) u_up (
        .value  (count_q),
        .step   (step),
        .bound  (upper_lim),
        .result (up_val)
    );

    udc_step_sat #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .SUBTRACT (1'b1)
    ) u_dn (
        .value  (count_q),
        .step   (step),
        .bound  (down_lim),
        .result (dn_val)
    );

    // Next count/dir/turn/done from load, mode and boundary compares
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        turn_d  = 1'b0;
        done_d  = done_q;
        if (load) begin
            count_d = data;
            done_d  = 1'b0;
            dir_d   = (mode_sel == MODE_WRAP_DN) ||
                      ((mode_sel == MODE_BOUNCE) && (data >= upper_lim));
        end else if (en && !cfg_err) begin
            case (mode_sel)
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        if (count_q >= upper_lim) begin
                            count_d = dn_val;
                            dir_d   = 1'b1;
                            turn_d  = 1'b1;
                        end else begin
                            count_d = up_val;
                        end
                    end else begin
                        if (count_q <= down_lim) begin
                            count_d = up_val;
                            dir_d   = 1'b0;
                            turn_d  = 1'b1;
                        end else begin
                            count_d = dn_val;
                        end
                    end
                end
                MODE_WRAP_UP: begin
                    dir_d = 1'b0;
                    if (count_q >= upper_lim) begin
                        count_d = down_lim;
                        turn_d  = 1'b1;
                    end else begin
                        count_d = up_val;
                    end
                end
                MODE_WRAP_DN: begin
                    dir_d = 1'b1;
                    if (count_q <= down_lim) begin
                        count_d = upper_lim;
                        turn_d  = 1'b1;
                    end else begin
                        count_d = dn_val;
                    end
                end
                default: begin
                    // MODE_ONESHOT: done is raised alongside the count that lands on the limit
                    dir_d = 1'b0;
                    if (count_q >= upper_lim) begin
                        done_d = 1'b1;
                    end else begin
                        count_d = up_val;
                        if (up_val >= upper_lim) begin
                            done_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Main state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
            dir_q   <= 1'b0;
            turn_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign turn  = turn_q;
    assign done  = done_q;

`ifdef UDC_TURN_CNT_EN
    logic [TC_W-1:0] turn_cnt_q, turn_cnt_d;

    // Saturating turn tally, cleared by load
    always_comb begin
        turn_cnt_d = turn_cnt_q;
        if (load) begin
            turn_cnt_d = '0;
        end else if (turn_d && (turn_cnt_q != {TC_W{1'b1}})) begin
            turn_cnt_d = turn_cnt_q + TC_W'(1);
        end
    end

    // Turn counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            turn_cnt_q <= '0;
        end else begin
            turn_cnt_q <= turn_cnt_d;
        end
    end

    assign turn_cnt = turn_cnt_q;
`else
    // TC_W only sizes the turn counter, which this build omits
    logic unused_tc_w;
    assign unused_tc_w = (TC_W != 0);
`endif

endmodule

// File: tb/tb_bounce_counter_multimode.sv
// Self-checking bench for bounce_counter_multimode: integer reference model compared every
// cycle, plus literal sequences. Turn counter checks are built when UDC_TURN_CNT_EN is defined.
module tb_bounce_counter_multimode;

    localparam int unsigned W   = 16;
    localparam int unsigned SW  = 4;
    localparam int unsigned TCW = 2;
    localparam logic [15:0] RV  = 16'd5;

    logic          clk = 1'b0;
    logic          rst, en, load;
    logic [W-1:0]  data, upper_lim, down_lim;
    logic [SW-1:0] step;
    logic [1:0]    mode;
    logic [W-1:0]  count;
    logic          dir, turn, done, cfg_err;
`ifdef UDC_TURN_CNT_EN
    logic [TCW-1:0] turn_cnt;
`endif

    int errors = 0;
    int checks = 0;

    bounce_counter_multimode #(
        .WIDTH   (W),
        .STEP_W  (SW),
        .RST_VAL (RV),
        .TC_W    (TCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .data      (data),
        .upper_lim (upper_lim),
        .down_lim  (down_lim),
        .step      (step),
        .mode      (mode),
        .count     (count),
        .dir       (dir),
        .turn      (turn),
        .done      (done),
        .cfg_err   (cfg_err)
`ifdef UDC_TURN_CNT_EN
        ,
        .turn_cnt  (turn_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the mode rules
    int m_count, m_dir, m_turn, m_done, m_tc;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int c, u, d, upv, dnv;
        c   = m_count;
        u   = int'(upper_lim);
        d   = int'(down_lim);
        upv = (c + int'(step) > u) ? u : c + int'(step);
        dnv = (c - int'(step) < d) ? d : c - int'(step);
        m_turn = 0;
        if (rst) begin
            m_valid = 1'b1;
            m_count = int'(RV);
            m_dir   = 0;
            m_done  = 0;
            m_tc    = 0;
        end else if (load) begin
            m_count = int'(data);
            m_done  = 0;
            m_tc    = 0;
            m_dir   = (mode == 2 || (mode == 0 && data >= upper_lim)) ? 1 : 0;
        end else if (en && d <= u) begin
            case (mode)
                2'd0: begin
                    if (m_dir == 0 && c >= u) begin
                        m_count = dnv; m_dir = 1; m_turn = 1;
                    end else if (m_dir == 1 && c <= d) begin
                        m_count = upv; m_dir = 0; m_turn = 1;
                    end else begin
                        m_count = (m_dir == 0) ? upv : dnv;
                    end
                end
                2'd1: begin
                    m_dir = 0;
                    if (c >= u) begin m_count = d; m_turn = 1; end
                    else m_count = upv;
                end
                2'd2: begin
                    m_dir = 1;
                    if (c <= d) begin m_count = u; m_turn = 1; end
                    else m_count = dnv;
                end
                default: begin
                    m_dir = 0;
                    if (c < u) m_count = upv;
                    if (m_count >= u) m_done = 1;
                end
            endcase
        end
        if (m_turn == 1 && m_tc < (1 << TCW) - 1) m_tc++;
    end

    // Compare process: every cycle once reset has been seen
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_count", 32'(count), m_count);
            chk("m_dir", 32'(dir), m_dir);
            chk("m_turn", 32'(turn), m_turn);
            chk("m_done", 32'(done), m_done);
            chk("m_cfg_err", 32'(cfg_err), (down_lim > upper_lim) ? 1 : 0);
`ifdef UDC_TURN_CNT_EN
            chk("m_turn_cnt", 32'(turn_cnt), m_tc);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int md, input int dl, input int ul, input int st, input int dt);
        mode      = 2'(md);
        down_lim  = 16'(dl);
        upper_lim = 16'(ul);
        step      = 4'(st);
        data      = 16'(dt);
        load      = 1'b1;
        en        = 1'b0;
        tick();
        load      = 1'b0;
        en        = 1'b1;
    endtask

    initial begin
        int e1c[8] = '{2, 3, 4, 5, 4, 3, 2, 3};
        int e1t[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
        int e1d[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        int e2c[8] = '{0, 4, 8, 10, 6, 2, 0, 4};
        int e2t[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
        int e3c[5] = '{6, 4, 3, 6, 4};
        int e3t[5] = '{0, 0, 0, 1, 0};
        int e4c[5] = '{0, 1, 2, 3, 3};
        int e4d[5] = '{0, 0, 0, 1, 1};
        int e5c[5] = '{0, 2, 3, 0, 2};
        int e5t[5] = '{0, 0, 0, 1, 0};

        rst = 1'b1; en = 1'b0; load = 1'b0; data = '0;
        upper_lim = '0; down_lim = '0; step = '0; mode = 2'd0;
        tick();
        tick();
        chk("reset_count", 32'(count), 32'(RV));
        chk("reset_dir", 32'(dir), 0);
        chk("reset_turn", 32'(turn), 0);
        chk("reset_done", 32'(done), 0);
        rst = 1'b0;

        // Bounce 2..5 step 1
        load_cfg(0, 2, 5, 1, 2);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk("bounce1_count", 32'(count), e1c[i]);
            chk("bounce1_turn", 32'(turn), e1t[i]);
            chk("bounce1_dir", 32'(dir), e1d[i]);
        end

        // Bounce 0..10 step 4, clamped at both limits
        load_cfg(0, 0, 10, 4, 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk("bounce2_count", 32'(count), e2c[i]);
            chk("bounce2_turn", 32'(turn), e2t[i]);
        end

        // Wrap-down 3..6 step 2
        load_cfg(2, 3, 6, 2, 6);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk("wrapdn_count", 32'(count), e3c[i]);
            chk("wrapdn_turn", 32'(turn), e3t[i]);
            chk("wrapdn_dir", 32'(dir), 1);
        end

        // One-shot 0..3 step 1
        load_cfg(3, 0, 3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk("oneshot_count", 32'(count), e4c[i]);
            chk("oneshot_done", 32'(done), e4d[i]);
            chk("oneshot_turn", 32'(turn), 0);
        end
        tick();
        chk("oneshot_sticky", 32'(done), 1);
        load_cfg(3, 0, 3, 1, 0);
        chk("oneshot_load_clr", 32'(done), 0);

        // Wrap-up 0..3 step 2
        load_cfg(1, 0, 3, 2, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk("wrapup_count", 32'(count), e5c[i]);
            chk("wrapup_turn", 32'(turn), e5t[i]);
        end

        // Priority: rst over load over en
        rst = 1'b1; load = 1'b1; en = 1'b1; data = 16'd7;
        tick();
        chk("prio_rst", 32'(count), 32'(RV));
        rst = 1'b0; data = 16'd9;
        tick();
        chk("prio_load", 32'(count), 9);
        load = 1'b0;

        // Inverted limits: en ignored, load honoured
        mode = 2'd0; down_lim = 16'd8; upper_lim = 16'd4; en = 1'b1;
        #1;
        chk("cfg_err_high", 32'(cfg_err), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cfg_err_hold", 32'(count), 9);
            chk("cfg_err_turn", 32'(turn), 0);
        end
        load = 1'b1; data = 16'd1;
        tick();
        chk("cfg_err_load", 32'(count), 1);
        load = 1'b0;

        // Equal limits: hold at the limit, turn every enabled cycle
        load_cfg(0, 7, 7, 3, 7);
        chk("eq_dir", 32'(dir), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("eq_count", 32'(count), 7);
            chk("eq_turn", 32'(turn), 1);
        end

        // Mode change mid-run: wrap-down forces dir, bounce keeps it
        load_cfg(0, 0, 9, 1, 4);
        tick();
        chk("mchg_up", 32'(count), 5);
        mode = 2'd2;
        tick();
        chk("mchg_wd_count", 32'(count), 4);
        chk("mchg_wd_dir", 32'(dir), 1);
        mode = 2'd0;
        tick();
        chk("mchg_b_count", 32'(count), 3);
        chk("mchg_b_dir", 32'(dir), 1);

        // Six bounce turns between 0 and 1
        load_cfg(0, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) tick();
`ifdef UDC_TURN_CNT_EN
        chk("turn_cnt_sat", 32'(turn_cnt), 3);
`endif
        chk("tc_run_count", 32'(count), 1);

        en = 1'b0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
